m_interrupt_sequencer: RTL
==========================

# m_interrupt_sequencer

Machine-mode interrupt sequencer for the CSR unit. It arbitrates the three standard machine interrupt sources against `mie`, the privilege level and `mstatus.MIE`, and presents one stable request and cause to the commit stage. On acknowledge it performs the trap-entry update of `mstatus` and privilege and issues the `mcause` write; on `mret` it performs the trap-return update. It owns `mstatus.MIE/MPIE/MPP` and the current privilege level; the CSR unit mirrors these outputs for reads.

## Interface
- `XLEN`, 32, datapath width
- `ECODE_W`, 5, cause-code width
- `USER_MODE`, 1, U-mode supported (0: machine only)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `irq_external`  in  1  level, synchronous to `clk` (MEI, code 11)
- `irq_timer`  in  1  level (MTI, code 7)
- `irq_software`  in  1  level (MSI, code 3)
- `mie`  in  XLEN  mie CSR; only bits 11, 7 and 3 are used
- `mstatus_wr`  in  1  CSR write to mstatus this cycle
- `mstatus_wdata`  in  XLEN  write data; bit 3 = MIE, bit 7 = MPIE, bits 12:11 = MPP
- `mret`  in  1  mret commits this cycle (1-cycle pulse)
- `interrupt_ack`  in  1  commit stage takes the trap this cycle
- `interrupt_req`  out  1  interrupt request to commit
- `interrupt_cause`  out  ECODE_W  cause of the pending request
- `mcause_we`  out  1  mcause write strobe
- `mcause_wdata`  out  XLEN  {1'b1, zeros, cause}
- `mstatus_mie`, `mstatus_mpie`  out  1 each
- `mstatus_mpp`  out  2
- `privilege`  out  2  current privilege (00 = U, 11 = M)

## Operation
- Global enable `gen` = (`privilege` == U) | `mstatus_mie`. Per-source pending = `irq_x` & `mie[bit]`.
- Priority: MEI > MSI > MTI.
- FSM states:
  - IDLE: if `gen` and any source is pending, latch the highest-priority cause, go to REQ.
  - REQ: `interrupt_req` = 1 and the cause is frozen; a higher-priority arrival does not change it.
    - `interrupt_ack` → trap entry, go to IDLE.
    - No ack, and the latched source is no longer pending or `gen` = 0 → withdraw (req drops), go to IDLE.
    - Ack wins over a same-cycle withdraw.
- Trap entry (at the ack edge): `mpie` ← `mie`; `mie` ← 0; `mpp` ← `privilege`; `privilege` ← M. Next cycle: `mcause_we` = 1 for one cycle with `mcause_wdata` = {1, 0…, latched cause}.
- mret: `mie` ← `mpie`; `mpie` ← 1; `privilege` ← `mpp`; `mpp` ← U (M if `USER_MODE` = 0).
- mstatus write: loads MIE, MPIE and MPP. MPP is WARL: values 01 and 10 keep the old value; value 00 keeps the old value if `USER_MODE` = 0.
- Same-cycle conflicts:
  - ack > mret > `mstatus_wr` for the owned fields.
  - ack with mret is a protocol violation: mret is dropped and a simulation assertion fires.
- `interrupt_ack` while in IDLE is ignored and fires an assertion.

## Timing
- Reset values: state IDLE, `interrupt_req` 0, `interrupt_cause` 0, `mcause_we` 0, `mcause_wdata` 0, `mstatus_mie` 0, `mstatus_mpie` 0, `mstatus_mpp` 11, `privilege` 11.
- Reset mid-request drops `interrupt_req` on the next edge; no mcause write is issued.
- All outputs are registered.
- Latency:
  - Source pending at edge N (with `gen`) → `interrupt_req` high after edge N+1.
  - `mstatus`/`mie` updates are observed by the arbiter one cycle after they are registered.
  - Ack at edge A → `mcause_we` high during cycle A+1 only; `mstatus` outputs change after edge A.
  - Earliest new request after an mret that re-enables is 1 cycle after mret, plus 1 cycle for req registration.
- Handshake: `interrupt_req` and `interrupt_cause` stay stable until the ack edge or the withdraw edge. Req is low the cycle after ack, so there are no back-to-back requests (MIE = 0 and privilege = M).

## Test plan
- Timer source, `mie[7]` = 1, `mstatus_mie` = 1, privilege M → req after 1 cycle, cause 7; ack → `mcause_wdata` = 0x80000007 with a 1-cycle `mcause_we`; MIE = 0, MPIE = 1, MPP = 11.
- Timer and external raised together → cause 11. Then in REQ, software asserts → cause stays 11.
- Privilege U with `mstatus_mie` = 0, software IRQ enabled → req with cause 3; ack → privilege 11, MPP 00. mret → privilege 00, MIE = 0 (old MPIE), MPIE = 1.
- In REQ, `mstatus_wr` clears MIE at privilege M → req withdrawn, no `mcause_we`. Same clear coincident with ack → ack wins, trap taken.
- Write MPP = 10 → MPP unchanged. With `USER_MODE` = 0, mret → MPP stays 11 and privilege stays 11.
- `rst` asserted during REQ → next cycle all outputs equal their reset values; the pending source raises a fresh req only after MIE is set.

Source files
------------

// File: rtl/m_interrupt_sequencer_if.sv
// Request/ack and mstatus bundle between the CSR/commit side (master) and the interrupt sequencer (slave).
interface m_interrupt_sequencer_if #(
    parameter int XLEN    = 32,
    parameter int ECODE_W = 5
);
    logic               irq_external;
    logic               irq_timer;
    logic               irq_software;
    logic [XLEN-1:0]    mie;
    logic               mstatus_wr;
    logic [XLEN-1:0]    mstatus_wdata;
    logic               mret;
    logic               interrupt_ack;
    logic               interrupt_req;
    logic [ECODE_W-1:0] interrupt_cause;
    logic               mcause_we;
    logic [XLEN-1:0]    mcause_wdata;
    logic               mstatus_mie;
    logic               mstatus_mpie;
    logic [1:0]         mstatus_mpp;
    logic [1:0]         privilege;

    modport master (
        output irq_external, irq_timer, irq_software, mie, mstatus_wr, mstatus_wdata,
               mret, interrupt_ack,
        input  interrupt_req, interrupt_cause, mcause_we, mcause_wdata,
               mstatus_mie, mstatus_mpie, mstatus_mpp, privilege
    );

    modport slave (
        input  irq_external, irq_timer, irq_software, mie, mstatus_wr, mstatus_wdata,
               mret, interrupt_ack,
        output interrupt_req, interrupt_cause, mcause_we, mcause_wdata,
               mstatus_mie, mstatus_mpie, mstatus_mpp, privilege
    );
endinterface

// File: rtl/m_interrupt_sequencer.sv
// Machine-mode interrupt sequencer: arbitrates MEI > MSI > MTI and owns mstatus.MIE/MPIE/MPP and privilege.
// Request registers one cycle after a source is seen pending; req/cause hold until the ack or withdraw edge.
module m_interrupt_sequencer #(
    parameter int XLEN      = 32,
    parameter int ECODE_W   = 5,
    parameter int USER_MODE = 1
) (
    input  logic clk,
    input  logic rst,
    m_interrupt_sequencer_if.slave bus
);
    typedef enum logic {S_IDLE, S_REQ} state_t;

    localparam logic [1:0]         PRV_U   = 2'b00;
    localparam logic [1:0]         PRV_M   = 2'b11;
    localparam logic [1:0]         MPP_RET = (USER_MODE != 0) ? PRV_U : PRV_M;
    localparam logic [ECODE_W-1:0] CODE_EI = ECODE_W'(11);
    localparam logic [ECODE_W-1:0] CODE_TI = ECODE_W'(7);
    localparam logic [ECODE_W-1:0] CODE_SI = ECODE_W'(3);

    state_t             r_state;
    logic               r_req;
    logic [ECODE_W-1:0] r_cause;
    logic               r_mcause_we;
    logic [XLEN-1:0]    r_mcause_wdata;
    logic               r_mie;
    logic               r_mpie;
    logic [1:0]         r_mpp;
    logic [1:0]         r_priv;

    logic               w_gen;
    logic               w_pend_ei;
    logic               w_pend_ti;
    logic               w_pend_si;
    logic               w_any;
    logic               w_latched_pend;
    logic               w_take_trap;
    logic [ECODE_W-1:0] w_sel_cause;
    logic [1:0]         w_wr_mpp;
    logic               w_unused;

    assign w_gen     = (r_priv == PRV_U) | r_mie;
    assign w_pend_ei = bus.irq_external & bus.mie[11];
    assign w_pend_ti = bus.irq_timer    & bus.mie[7];
    assign w_pend_si = bus.irq_software & bus.mie[3];
    assign w_any     = w_pend_ei | w_pend_ti | w_pend_si;

    assign w_sel_cause = w_pend_ei ? CODE_EI : (w_pend_si ? CODE_SI : CODE_TI);

    // Withdraw tracks only the source that was latched, not whichever is now highest.
    assign w_latched_pend = ((r_cause == CODE_EI) & w_pend_ei)
                          | ((r_cause == CODE_TI) & w_pend_ti)
                          | ((r_cause == CODE_SI) & w_pend_si);

    assign w_take_trap = (r_state == S_REQ) & bus.interrupt_ack;

    // MPP is WARL: reserved encodings, and U when U-mode is absent, leave the field untouched.
    always_comb begin
        w_wr_mpp = r_mpp;
        if (bus.mstatus_wdata[12:11] == PRV_M) begin
            w_wr_mpp = PRV_M;
        end else if ((bus.mstatus_wdata[12:11] == PRV_U) && (USER_MODE != 0)) begin
            w_wr_mpp = PRV_U;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_req          <= 1'b0;
            r_cause        <= '0;
            r_mcause_we    <= 1'b0;
            r_mcause_wdata <= '0;
            r_mie          <= 1'b0;
            r_mpie         <= 1'b0;
            r_mpp          <= PRV_M;
            r_priv         <= PRV_M;
        end else begin
            r_mcause_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gen && w_any) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_cause <= w_sel_cause;
                    end
                end
                S_REQ: begin
                    if (bus.interrupt_ack) begin
                        r_state        <= S_IDLE;
                        r_req          <= 1'b0;
                        r_mcause_we    <= 1'b1;
                        r_mcause_wdata <= {1'b1, {(XLEN-1-ECODE_W){1'b0}}, r_cause};
                    end else if (!w_gen || !w_latched_pend) begin
                        r_state <= S_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_take_trap) begin
                r_mpie <= r_mie;
                r_mie  <= 1'b0;
                r_mpp  <= r_priv;
                r_priv <= PRV_M;
            end else if (bus.mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
                r_priv <= r_mpp;
                r_mpp  <= MPP_RET;
            end else if (bus.mstatus_wr) begin
                r_mie  <= bus.mstatus_wdata[3];
                r_mpie <= bus.mstatus_wdata[7];
                r_mpp  <= w_wr_mpp;
            end
        end
    end

    assign bus.interrupt_req   = r_req;
    assign bus.interrupt_cause = r_cause;
    assign bus.mcause_we       = r_mcause_we;
    assign bus.mcause_wdata    = r_mcause_wdata;
    assign bus.mstatus_mie     = r_mie;
    assign bus.mstatus_mpie    = r_mpie;
    assign bus.mstatus_mpp     = r_mpp;
    assign bus.privilege       = r_priv;

    assign w_unused = ^{bus.mie[XLEN-1:12], bus.mie[10:8], bus.mie[6:4], bus.mie[2:0],
                        bus.mstatus_wdata[XLEN-1:13], bus.mstatus_wdata[10:8],
                        bus.mstatus_wdata[6:4], bus.mstatus_wdata[2:0]};

    a_ack_with_mret: assert property (@(posedge clk) disable iff (rst)
        !(bus.interrupt_ack && bus.mret));
    a_ack_in_idle: assert property (@(posedge clk) disable iff (rst)
        bus.interrupt_ack |-> (r_state == S_REQ));
endmodule
